// File: rtl/ddr3_tl_arbiter.sv
// ddr3_tl_arbiter
//   Two-master round-robin arbiter in front of a DDR3 TileLink-UL slave port
//   (Get / PutFull, 64-byte blocks, eight 64-bit beats per PutFull).
//   A master owns the A channel for a whole burst, so beats from the two
//   masters never interleave. a_source is tagged with the master index in its
//   MSB, and D beats are routed back by that tag. A per-master outstanding
//   counter stops one master from filling the slave's source FIFOs.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   m{0,1}_a_*                   master A channel (valid/ready/opcode/source/address/data)
//   m{0,1}_d_*                   master D channel (valid/ready/opcode/source/data)
//   s_a_*                        slave A channel; size/mask/param are constant
//   s_d_*                        slave D channel; source MSB selects the master

// Per-master outstanding-transaction counter and eligibility.
module ddr3_tl_arbiter_outcnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_valid,
  input  logic inc,
  input  logic dec,
  output logic eligible
);
  logic [2:0] cnt;

  // Simultaneous issue and completion leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)            cnt <= '0;
    else if (inc && !dec)    cnt <= cnt + 3'd1;
    else if (dec && !inc)    cnt <= cnt - 3'd1;

  assign eligible = a_valid && (cnt < 3'(MAX_OUTSTANDING));

  // A completion with nothing outstanding is a slave protocol error.
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(dec && !inc && cnt == 3'd0));
endmodule

module ddr3_tl_arbiter #(
  parameter int ADDRESS_WIDTH   = 30,
  parameter int SOURCE_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     m0_a_valid,
  output logic                     m0_a_ready,
  input  logic [2:0]               m0_a_opcode,
  input  logic [SOURCE_WIDTH-1:0]  m0_a_source,
  input  logic [ADDRESS_WIDTH-1:0] m0_a_address,
  input  logic [63:0]              m0_a_data,
  output logic                     m0_d_valid,
  input  logic                     m0_d_ready,
  output logic [2:0]               m0_d_opcode,
  output logic [SOURCE_WIDTH-1:0]  m0_d_source,
  output logic [63:0]              m0_d_data,
  input  logic                     m1_a_valid,
  output logic                     m1_a_ready,
  input  logic [2:0]               m1_a_opcode,
  input  logic [SOURCE_WIDTH-1:0]  m1_a_source,
  input  logic [ADDRESS_WIDTH-1:0] m1_a_address,
  input  logic [63:0]              m1_a_data,
  output logic                     m1_d_valid,
  input  logic                     m1_d_ready,
  output logic [2:0]               m1_d_opcode,
  output logic [SOURCE_WIDTH-1:0]  m1_d_source,
  output logic [63:0]              m1_d_data,
  output logic                     s_a_valid,
  input  logic                     s_a_ready,
  output logic [2:0]               s_a_opcode,
  output logic [SOURCE_WIDTH:0]    s_a_source,
  output logic [ADDRESS_WIDTH-1:0] s_a_address,
  output logic [63:0]              s_a_data,
  output logic [2:0]               s_a_size,
  output logic [7:0]               s_a_mask,
  output logic [2:0]               s_a_param,
  input  logic                     s_d_valid,
  output logic                     s_d_ready,
  input  logic [2:0]               s_d_opcode,
  input  logic [SOURCE_WIDTH:0]    s_d_source,
  input  logic [63:0]              s_d_data
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] BUSY   = 1'b1;
  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_ACK = 3'd0;
  localparam logic [2:0] OP_RD  = 3'd1;

  // Master-side signals packed by index so the owner can select them.
  logic [1:0]                          a_valid, d_ready, elig, inc, dec;
  logic [1:0][2:0]                     a_opcode;
  logic [1:0][SOURCE_WIDTH-1:0]        a_source;
  logic [1:0][ADDRESS_WIDTH-1:0]       a_address;
  logic [1:0][63:0]                    a_data;

  assign a_valid   = {m1_a_valid,   m0_a_valid};
  assign a_opcode  = {m1_a_opcode,  m0_a_opcode};
  assign a_source  = {m1_a_source,  m0_a_source};
  assign a_address = {m1_a_address, m0_a_address};
  assign a_data    = {m1_a_data,    m0_a_data};
  assign d_ready   = {m1_d_ready,   m0_d_ready};

  logic [0:0] state;
  logic       owner, last_owner, other, sel;
  logic [2:0] a_beat, d_beat;
  logic       a_fire, a_last, d_fire, d_last;

  assign other = ~owner;

  // ---------------- A channel ----------------
  assign s_a_valid   = (state == BUSY) && a_valid[owner];
  assign m0_a_ready  = (state == BUSY) && !owner && s_a_ready;
  assign m1_a_ready  = (state == BUSY) &&  owner && s_a_ready;
  assign s_a_opcode  = a_opcode[owner];
  assign s_a_source  = {owner, a_source[owner]};
  assign s_a_address = a_address[owner];
  assign s_a_data    = a_data[owner];
  assign s_a_size    = 3'd6;
  assign s_a_mask    = 8'hFF;
  assign s_a_param   = 3'd0;

  assign a_fire = s_a_valid && s_a_ready;
  assign a_last = a_fire && (a_opcode[owner] == OP_GET || a_beat == 3'd7);

  // ---------------- D channel ----------------
  // Gated by reset_n so nothing handshakes while reset is held.
  assign sel         = s_d_source[SOURCE_WIDTH];
  assign s_d_ready   = reset_n && d_ready[sel];
  assign m0_d_valid  = reset_n && s_d_valid && !sel;
  assign m1_d_valid  = reset_n && s_d_valid &&  sel;
  assign m0_d_opcode = s_d_opcode;
  assign m1_d_opcode = s_d_opcode;
  assign m0_d_source = s_d_source[SOURCE_WIDTH-1:0];
  assign m1_d_source = s_d_source[SOURCE_WIDTH-1:0];
  assign m0_d_data   = s_d_data;
  assign m1_d_data   = s_d_data;

  assign d_fire = s_d_valid && s_d_ready;
  assign d_last = d_fire && (s_d_opcode == OP_ACK || (s_d_opcode == OP_RD && d_beat == 3'd7));

  assign inc = {a_last &&  owner, a_last && !owner};
  assign dec = {d_last &&  sel,   d_last && !sel};

  for (genvar i = 0; i < 2; i++) begin : g_m
    ddr3_tl_arbiter_outcnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .a_valid  (a_valid[i]),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .eligible (elig[i])
    );
  end

  // Grant FSM: IDLE costs one bubble; a burst end hands straight over to a
  // waiting eligible master.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      a_beat     <= 3'd0;
    end else if (state == IDLE) begin
      if (elig[0] && elig[1]) begin
        state <= BUSY;
        owner <= ~last_owner;
      end else if (elig[0]) begin
        state <= BUSY;
        owner <= 1'b0;
      end else if (elig[1]) begin
        state <= BUSY;
        owner <= 1'b1;
      end
    end else begin
      if (a_last) begin
        a_beat     <= 3'd0;
        last_owner <= owner;
        if (elig[other]) owner <= other;
        else             state <= IDLE;
      end else if (a_fire) begin
        a_beat <= a_beat + 3'd1;
      end
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                            d_beat <= 3'd0;
    else if (d_last)                         d_beat <= 3'd0;
    else if (d_fire && s_d_opcode == OP_RD)  d_beat <= d_beat + 3'd1;
endmodule

// File: tb/tb_ddr3_tl_arbiter.sv
// Bench for ddr3_tl_arbiter: directed tests with a transaction-level
// reference model checked every cycle, plus literal expectations.
module tb_ddr3_tl_arbiter;
  localparam int AW = 30, SW = 4, MAXO = 2;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [2:0] op; logic [SW-1:0] src; logic [AW-1:0] addr; } req_t;
  typedef struct { int cyc; logic [SW:0] src; logic [63:0] data; } beat_t;

  req_t  mq [2][$];
  beat_t alog[$];
  int    cyc = 0;
  int    checks = 0, errors = 0;

  logic          mv [2];
  logic [2:0]    mop [2];
  logic [SW-1:0] msrc [2];
  logic [AW-1:0] maddr [2];
  logic [63:0]   mdat [2];
  logic          dr [2];
  logic          s_a_ready, s_d_valid;
  logic [2:0]    s_d_opcode;
  logic [SW:0]   s_d_source;
  logic [63:0]   s_d_data;

  logic          m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_a_valid, s_d_ready;
  logic [2:0]    m0_d_opcode, m1_d_opcode, s_a_opcode, s_a_size, s_a_param;
  logic [SW-1:0] m0_d_source, m1_d_source;
  logic [63:0]   m0_d_data, m1_d_data, s_a_data;
  logic [SW:0]   s_a_source;
  logic [AW-1:0] s_a_address;
  logic [7:0]    s_a_mask;

  ddr3_tl_arbiter #(.ADDRESS_WIDTH(AW), .SOURCE_WIDTH(SW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_a_valid(mv[0]), .m0_a_ready(m0_a_ready), .m0_a_opcode(mop[0]), .m0_a_source(msrc[0]),
    .m0_a_address(maddr[0]), .m0_a_data(mdat[0]),
    .m0_d_valid(m0_d_valid), .m0_d_ready(dr[0]), .m0_d_opcode(m0_d_opcode),
    .m0_d_source(m0_d_source), .m0_d_data(m0_d_data),
    .m1_a_valid(mv[1]), .m1_a_ready(m1_a_ready), .m1_a_opcode(mop[1]), .m1_a_source(msrc[1]),
    .m1_a_address(maddr[1]), .m1_a_data(mdat[1]),
    .m1_d_valid(m1_d_valid), .m1_d_ready(dr[1]), .m1_d_opcode(m1_d_opcode),
    .m1_d_source(m1_d_source), .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_size(s_a_size), .s_a_mask(s_a_mask),
    .s_a_param(s_a_param),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_source(s_d_source), .s_d_data(s_d_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave-side A beat log.
  initial forever begin
    @(negedge clk);
    if (s_a_valid && s_a_ready) alog.push_back('{cyc, s_a_source, s_a_data});
  end

  // Master engines: present the head request, advance one beat per handshake.
  for (genvar g = 0; g < 2; g++) begin : g_eng
    initial begin
      int   beat;
      logic f;
      beat = 0;
      mv[g] = 1'b0; mop[g] = '0; msrc[g] = '0; maddr[g] = '0; mdat[g] = '0;
      forever begin
        @(negedge clk);
        f = mv[g] && ((g == 0) ? m0_a_ready : m1_a_ready);
        @(posedge clk); #1;
        if (!reset_n) beat = 0;
        else if (f) begin
          if (mop[g] == 3'd4 || beat == 7) begin
            beat = 0;
            if (mq[g].size() > 0) void'(mq[g].pop_front());
          end else beat++;
        end
        mv[g] = reset_n && (mq[g].size() > 0);
        if (mq[g].size() > 0) begin
          mop[g] = mq[g][0].op; msrc[g] = mq[g][0].src; maddr[g] = mq[g][0].addr;
        end
        mdat[g] = {8'(g), 4'h0, msrc[g], maddr[g][15:0], 24'h0, 5'h0, 3'(beat)};
      end
    end
  end

  // Reference model: who holds the grant, beats left in the current burst /
  // response, transactions outstanding per master. Checked every cycle.
  initial begin
    bit   busy, afire, aend, dend;
    int   own, last, rem_a, rem_d, sel;
    int   outst [2];
    bit   elig [2];
    logic e_sav, e_ar [2], e_dv [2], e_sdr;
    busy = 0; own = 0; last = 1; rem_a = 0; rem_d = 0; outst[0] = 0; outst[1] = 0;
    forever begin
      @(negedge clk);
      chk("s_a_size", 64'(s_a_size), 64'd6);
      chk("s_a_mask", 64'(s_a_mask), 64'hFF);
      chk("s_a_param", 64'(s_a_param), 64'd0);
      if (!reset_n) begin
        chk("rst_s_a_valid", 64'(s_a_valid), 0);
        chk("rst_m0_a_ready", 64'(m0_a_ready), 0);
        chk("rst_m1_a_ready", 64'(m1_a_ready), 0);
        chk("rst_s_d_ready", 64'(s_d_ready), 0);
        chk("rst_m0_d_valid", 64'(m0_d_valid), 0);
        chk("rst_m1_d_valid", 64'(m1_d_valid), 0);
        busy = 0; own = 0; last = 1; rem_a = 0; rem_d = 0; outst[0] = 0; outst[1] = 0;
        continue;
      end
      sel = int'(s_d_source[SW]);
      e_sav = busy && mv[own];
      for (int i = 0; i < 2; i++) begin
        e_ar[i] = busy && own == i && s_a_ready;
        e_dv[i] = s_d_valid && sel == i;
      end
      e_sdr = dr[sel];
      chk("s_a_valid", 64'(s_a_valid), 64'(e_sav));
      chk("m0_a_ready", 64'(m0_a_ready), 64'(e_ar[0]));
      chk("m1_a_ready", 64'(m1_a_ready), 64'(e_ar[1]));
      chk("m0_d_valid", 64'(m0_d_valid), 64'(e_dv[0]));
      chk("m1_d_valid", 64'(m1_d_valid), 64'(e_dv[1]));
      chk("s_d_ready", 64'(s_d_ready), 64'(e_sdr));
      if (e_sav) begin
        chk("s_a_source", 64'(s_a_source), 64'({1'(own), msrc[own]}));
        chk("s_a_opcode", 64'(s_a_opcode), 64'(mop[own]));
        chk("s_a_address", 64'(s_a_address), 64'(maddr[own]));
        chk("s_a_data", s_a_data, mdat[own]);
      end
      if (e_dv[0]) chk("m0_d_payload", {m0_d_data[55:0], 1'b0, m0_d_opcode, m0_d_source},
                       {s_d_data[55:0], 1'b0, s_d_opcode, s_d_source[SW-1:0]});
      if (e_dv[1]) chk("m1_d_payload", {m1_d_data[55:0], 1'b0, m1_d_opcode, m1_d_source},
                       {s_d_data[55:0], 1'b0, s_d_opcode, s_d_source[SW-1:0]});
      // advance to the state after the coming edge
      for (int i = 0; i < 2; i++) elig[i] = mv[i] && outst[i] < MAXO;
      afire = e_sav && s_a_ready;
      aend = 0;
      if (afire) begin
        if (rem_a == 0) rem_a = (mop[own] == 3'd4) ? 1 : 8;
        rem_a--;
        aend = (rem_a == 0);
      end
      dend = 0;
      if (s_d_valid && e_sdr) begin
        if (rem_d == 0) rem_d = (s_d_opcode == 3'd1) ? 8 : 1;
        rem_d--;
        dend = (rem_d == 0);
      end
      if (aend) outst[own]++;
      if (dend) outst[sel]--;
      if (!busy) begin
        if (elig[0] && elig[1]) begin busy = 1; own = 1 - last; end
        else if (elig[0])       begin busy = 1; own = 0; end
        else if (elig[1])       begin busy = 1; own = 1; end
      end else if (aend) begin
        last = own;
        if (elig[1-own]) own = 1 - own;
        else             busy = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic [2:0] op, input logic [SW-1:0] src,
                      input logic [AW-1:0] addr);
    req_t r;
    r.op = op; r.src = src; r.addr = addr;
    mq[i].push_back(r);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mq[0].delete(); mq[1].delete();
    s_d_valid = 1'b0; s_a_ready = 1'b1; dr[0] = 1'b1; dr[1] = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(1);
    alog.delete();
  endtask

  task automatic wait_log(input int n, input int maxc);
    int t;
    t = 0;
    while (alog.size() < n && t < maxc) begin @(posedge clk); t++; end
    #2;
    chk("wait_a_beats", 64'(alog.size() >= n), 64'd1);
  endtask

  task automatic send_d(input logic [SW:0] src, input logic [2:0] op, input int n,
                        output int lastcyc, output int to0, output int to1);
    int t; logic acc;
    to0 = 0; to1 = 0; lastcyc = 0;
    for (int k = 0; k < n; k++) begin
      s_d_valid = 1'b1; s_d_source = src; s_d_opcode = op; s_d_data = 64'hD000 + 64'(k);
      t = 0; acc = 1'b0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = s_d_ready;
        if (acc) begin lastcyc = cyc; to0 += int'(m0_d_valid); to1 += int'(m1_d_valid); end
        @(posedge clk); #2;
        t++;
      end
      chk("d_accept", 64'(acc), 64'd1);
    end
    s_d_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lc, t0, t1;
    s_a_ready = 1'b1; s_d_valid = 1'b0; s_d_opcode = '0; s_d_source = '0; s_d_data = '0;
    dr[0] = 1'b1; dr[1] = 1'b1;

    // 1: single Get, arbitration bubble, ReadData routed to m0
    do_reset();
    chk("t1_reset_s_a_valid", 64'(s_a_valid), 0);
    push(0, 3'd4, 4'd3, 30'h1000);
    step(1);
    @(negedge clk);
    chk("t1_bubble", 64'(s_a_valid), 0);
    @(negedge clk);
    chk("t1_grant", 64'(s_a_valid), 1);
    chk("t1_src", 64'(s_a_source), 64'h03);
    chk("t1_addr", 64'(s_a_address), 64'h1000);
    step(1);
    send_d(5'h03, 3'd1, 8, lc, t0, t1);
    chk("t1_d_m0", 64'(t0), 8);
    chk("t1_d_m1", 64'(t1), 0);

    // 2: simultaneous PutFulls, m0 first, handover without a bubble
    do_reset();
    push(0, 3'd0, 4'd1, 30'h2000);
    push(1, 3'd0, 4'd2, 30'h3000);
    wait_log(16, 60);
    for (int k = 0; k < 16 && k < alog.size(); k++) begin
      chk("t2_owner", 64'(alog[k].src[SW]), 64'(k >= 8));
      chk("t2_contig", 64'(alog[k].cyc - alog[0].cyc), 64'(k));
      chk("t2_beat", 64'(alog[k].data[2:0]), 64'(k % 8));
    end
    send_d(5'h01, 3'd0, 1, lc, t0, t1);
    send_d(5'h12, 3'd0, 1, lc, t0, t1);
    chk("t2_ack_m1", 64'(t1), 1);

    // 3: slave stall mid-burst keeps the grant and the beat position
    do_reset();
    push(0, 3'd0, 4'd2, 30'h40);
    push(1, 3'd4, 4'd5, 30'h80);
    wait_log(4, 40);
    s_a_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_valid", 64'(s_a_valid), 1);
      chk("t3_stall_m1_ready", 64'(m1_a_ready), 0);
      chk("t3_stall_beat", 64'(s_a_data[2:0]), 4);
    end
    @(posedge clk); #2;
    s_a_ready = 1'b1;
    wait_log(9, 40);
    if (alog.size() >= 9) begin
      chk("t3_resume_gap", 64'(alog[4].cyc - alog[3].cyc), 4);
      for (int k = 4; k < 8; k++) chk("t3_tail_beat", 64'(alog[k].data[2:0]), 64'(k));
      chk("t3_m1_src", 64'(alog[8].src), 64'h15);
      chk("t3_m1_nobubble", 64'(alog[8].cyc - alog[7].cyc), 1);
    end
    send_d(5'h02, 3'd0, 1, lc, t0, t1);
    send_d(5'h15, 3'd1, 8, lc, t0, t1);
    chk("t3_rd_m1", 64'(t1), 8);

    // 4: D routing and back-pressure by source tag
    do_reset();
    dr[0] = 1'b1; dr[1] = 1'b0;
    s_d_valid = 1'b1; s_d_source = 5'h12; s_d_opcode = 3'd1; s_d_data = 64'hABCD;
    @(negedge clk);
    chk("t4_m1_d_valid", 64'(m1_d_valid), 1);
    chk("t4_m0_d_valid", 64'(m0_d_valid), 0);
    chk("t4_s_d_ready", 64'(s_d_ready), 0);
    chk("t4_m1_d_source", 64'(m1_d_source), 64'h2);
    step(1);
    s_d_source = 5'h05; dr[0] = 1'b0; dr[1] = 1'b1;
    @(negedge clk);
    chk("t4b_m0_d_valid", 64'(m0_d_valid), 1);
    chk("t4b_m1_d_valid", 64'(m1_d_valid), 0);
    chk("t4b_s_d_ready", 64'(s_d_ready), 0);
    step(1);
    s_d_valid = 1'b0;

    // 5: outstanding limit of 2 on m0
    do_reset();
    push(0, 3'd4, 4'd1, 30'h100);
    push(0, 3'd4, 4'd2, 30'h140);
    push(0, 3'd4, 4'd3, 30'h180);
    wait_log(2, 40);
    step(6);
    chk("t5_third_held", 64'(alog.size()), 2);
    push(1, 3'd4, 4'd7, 30'h200);
    wait_log(3, 20);
    if (alog.size() >= 3) chk("t5_m1_src", 64'(alog[2].src), 64'h17);
    step(3);
    chk("t5_still_held", 64'(alog.size()), 3);
    send_d(5'h01, 3'd1, 8, lc, t0, t1);
    wait_log(4, 20);
    if (alog.size() >= 4) begin
      chk("t5_third_src", 64'(alog[3].src), 64'h03);
      chk("t5_third_when", 64'(alog[3].cyc - lc), 2);
    end

    // 6: asynchronous reset mid-burst
    do_reset();
    push(0, 3'd0, 4'd9, 30'h500);
    wait_log(4, 40);
    s_d_valid = 1'b1; s_d_source = 5'h00; s_d_opcode = 3'd1;
    #1;
    chk("t6_pre_s_a_valid", 64'(s_a_valid), 1);
    chk("t6_pre_s_d_ready", 64'(s_d_ready), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_s_a_valid", 64'(s_a_valid), 0);
    chk("t6_m0_a_ready", 64'(m0_a_ready), 0);
    chk("t6_m1_a_ready", 64'(m1_a_ready), 0);
    chk("t6_s_d_ready", 64'(s_d_ready), 0);
    chk("t6_m0_d_valid", 64'(m0_d_valid), 0);
    chk("t6_m1_d_valid", 64'(m1_d_valid), 0);
    mq[0].delete(); mq[1].delete();
    s_d_valid = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    alog.delete();
    push(0, 3'd4, 4'd4, 30'h600);
    push(1, 3'd4, 4'd6, 30'h700);
    wait_log(2, 20);
    if (alog.size() >= 2) begin
      chk("t6_tie_m0_first", 64'(alog[0].src), 64'h04);
      chk("t6_then_m1", 64'(alog[1].src), 64'h16);
      chk("t6_no_bubble", 64'(alog[1].cyc - alog[0].cyc), 1);
    end
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
